// File: rtl/y86_decode_stage_if.sv
// Decode-stage bus: fetch inputs, hazard controls, register-file read port,
// forwarding sources and the E pipeline register outputs.
interface y86_decode_stage_if #(
  parameter int W = 64
);
  logic [2:0]   f_stat;
  logic [3:0]   f_icode, f_ifun, f_rA, f_rB;
  logic [W-1:0] f_valC, f_valP;

  logic         D_stall, D_bubble, E_bubble;

  logic [3:0]   srcA, srcB;
  logic [W-1:0] rvalA, rvalB;

  logic [3:0]   e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;

  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

  // Surrounding pipeline (fetch, hazard unit, register file, later stages).
  modport master (
    output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    output D_stall, D_bubble, E_bubble,
    input  srcA, srcB,
    output rvalA, rvalB,
    output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    output W_dstM, W_valM, W_dstE, W_valE,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB
  );

  // The decode stage itself.
  modport slave (
    input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
    input  D_stall, D_bubble, E_bubble,
    output srcA, srcB,
    input  rvalA, rvalB,
    input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    input  W_dstM, W_valM, W_dstE, W_valE,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: D pipeline register, register-ID decode, forwarding
// merge of register-file data, and the E pipeline register.
module y86_decode_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hf
) (
  input  logic              clock,
  input  logic              reset,
  y86_decode_stage_if.slave bus
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP   = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ   = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ = 4'hA, I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RSP      = 4'h4;
  localparam logic [2:0] STAT_AOK = 3'd1;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   rA;
    logic [3:0]   rB;
    logic [W-1:0] valC;
    logic [W-1:0] valP;
  } d_reg_t;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
  } e_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: '0, valP: '0};
  localparam e_reg_t E_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

  d_reg_t       d_q, d_d;
  e_reg_t       e_q, e_d;
  logic [3:0]   src_a, src_b, dst_e, dst_m;
  logic [W-1:0] d_val_a, d_val_b;

  // Stall outranks bubble: a stalled D keeps its instruction.
  always_comb begin
    // NOTE: give d_d a default before any branch so no path leaves it unassigned (no latch).
    d_d = d_q;
    if (!bus.D_stall) begin
      if (bus.D_bubble) begin
        d_d = D_BUBBLE;
      end else begin
        d_d = '{stat: bus.f_stat, icode: bus.f_icode, ifun: bus.f_ifun,
                rA: bus.f_rA, rB: bus.f_rB, valC: bus.f_valC, valP: bus.f_valP};
      end
    end
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      I_RRMOVQ: begin src_a = d_q.rA; dst_e = d_q.rB; end
      I_IRMOVQ: begin dst_e = d_q.rB; end
      I_RMMOVQ: begin src_a = d_q.rA; src_b = d_q.rB; end
      I_MRMOVQ: begin src_b = d_q.rB; dst_m = d_q.rA; end
      I_OPQ:    begin src_a = d_q.rA; src_b = d_q.rB; dst_e = d_q.rB; end
      I_CALL:   begin src_b = RSP; dst_e = RSP; end
      I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = d_q.rA; src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = d_q.rA; end
      default:  ;
    endcase
  end

  // Youngest producer wins; RNONE sources are filtered before any dst compare.
  always_comb begin
    if (d_q.icode == I_JXX || d_q.icode == I_CALL) d_val_a = d_q.valP;
    else if (src_a == RNONE)                       d_val_a = '0;
    else if (src_a == bus.e_dstE)                  d_val_a = bus.e_valE;
    else if (src_a == bus.M_dstM)                  d_val_a = bus.m_valM;
    else if (src_a == bus.M_dstE)                  d_val_a = bus.M_valE;
    else if (src_a == bus.W_dstM)                  d_val_a = bus.W_valM;
    else if (src_a == bus.W_dstE)                  d_val_a = bus.W_valE;
    else                                           d_val_a = bus.rvalA;

    if (src_b == RNONE)           d_val_b = '0;
    else if (src_b == bus.e_dstE) d_val_b = bus.e_valE;
    else if (src_b == bus.M_dstM) d_val_b = bus.m_valM;
    else if (src_b == bus.M_dstE) d_val_b = bus.M_valE;
    else if (src_b == bus.W_dstM) d_val_b = bus.W_valM;
    else if (src_b == bus.W_dstE) d_val_b = bus.W_valE;
    else                          d_val_b = bus.rvalB;
  end

  always_comb begin
    e_d = E_BUBBLE;
    if (!bus.E_bubble) begin
      e_d = '{stat: d_q.stat, icode: d_q.icode, ifun: d_q.ifun, valC: d_q.valC,
              valA: d_val_a, valB: d_val_b, dstE: dst_e, dstM: dst_m,
              srcA: src_a, srcB: src_b};
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      d_q <= D_BUBBLE;
      e_q <= E_BUBBLE;
    end else begin
      d_q <= d_d;
      e_q <= e_d;
    end
  end

  assign bus.srcA    = src_a;
  assign bus.srcB    = src_b;
  assign bus.E_stat  = e_q.stat;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_valC  = e_q.valC;
  assign bus.E_valA  = e_q.valA;
  assign bus.E_valB  = e_q.valB;
  assign bus.E_dstE  = e_q.dstE;
  assign bus.E_dstM  = e_q.dstM;
  assign bus.E_srcA  = e_q.srcA;
  assign bus.E_srcB  = e_q.srcB;

endmodule
